// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, halt encoding, opcode
// constants and the fetch-stage state type.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_J   = 6'b010100;
  localparam logic [5:0] OP_JAL = 6'b010110;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Major opcode field of an instruction word.
  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/return, redirect
// input from later stages, and the valid/ready output to decode.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 10
);
  import cpu_pkg::*;

  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_vld;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               halted;

  modport master (
    output imem_en, imem_addr, out_valid, out_instr, out_pc, halted,
    input  imem_rdata, redirect_vld, redirect_pc, out_ready
  );

  modport slave (
    input  imem_en, imem_addr, out_valid, out_instr, out_pc, halted,
    output imem_rdata, redirect_vld, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {instr, pc} entries. Flush empties it;
// head is the oldest entry and is only meaningful while count != 0.
module fetch_buffer #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; flush discards every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; no reset needed since head is qualified by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle
// synchronous instruction memory, buffers returns with their PC and hands
// them to decode over valid/ready. Redirects flush everything not yet
// consumed. Optional halt detection is enabled by defining HALT_DETECT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  inflight_pc_q;
  logic               inflight_q;
  logic               drop_q;

  logic               flush;
  logic               issue;
  logic               push;
  logic               pop;
  logic               valid;
  logic               halt_now;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     need;
  logic [ENTRY_W-1:0] head;

  assign flush = bus.redirect_vld;
  assign valid = (count != '0);
  assign pop   = valid & bus.out_ready;

  // Slots already spoken for after this cycle's pop; an issue is allowed
  // only if its return is guaranteed a free entry.
  assign need  = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};

  // rst_n gates the request so imem_en drops the moment reset asserts.
  assign issue = rst_n & (state_q == RUN) & ~flush & (need < (CNT_W + 1)'(BUF_DEPTH));
  assign push  = inflight_q & ~drop_q & ~flush;

  fetch_buffer #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({bus.imem_rdata, inflight_pc_q}),
    .head  (head),
    .count (count)
  );

`ifdef HALT_DETECT_EN
  logic halted_q;

  assign halt_now   = inflight_q & ~drop_q & ~flush & (state_q == RUN) &
                      (bus.imem_rdata == HALT_INSTR);
  assign bus.halted = halted_q;
`else
  assign halt_now   = 1'b0;
  assign bus.halted = 1'b0;
`endif

  // PC advance, in-flight tracking and discard of stale returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      if (flush) begin
        pc_q   <= bus.redirect_pc;
        drop_q <= inflight_q;
      end else begin
        if (issue) pc_q <= pc_q + 1'b1;
        // A fetch issued alongside the halt word must not be buffered.
        drop_q <= halt_now & issue;
      end
    end
  end

  // Fetch FSM: halt word stops issuing; only a redirect restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
`ifdef HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else if (flush) begin
      state_q  <= RUN;
`ifdef HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else if (halt_now) begin
      state_q  <= HALT;
`ifdef HALT_DETECT_EN
      halted_q <= 1'b1;
`endif
    end
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? head[ENTRY_W-1:ADDR_W] : '0;
  assign bus.out_pc    = valid ? head[ADDR_W-1:0]       : '0;

endmodule
